dbg_run_control: RTL and testbench

Run-control engine in the sys_clk domain, directly downstream of the JTAG test logic's CDC strobe synchronizers. It consumes single-cycle halt/step/resume/reset strobes and produces the glitch-free gated core clock (dbg_clk), a timed core reset, and debug status. It replaces the bare run/halt/step gate with three additions: halt waits for a core-idle boundary (with timeout), steps run N cycles, and enabled core cycles are counted.

---
 rtl/dbg_run_control_if.sv | 31 +++
 rtl/dbg_run_control.sv | 162 ++++++++++++++++
 tb/tb_dbg_run_control.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_run_control_if.sv
// Run-control bus: JTAG-side strobes and core handshake in, gated clock and
// debug status out. The run-control engine is the slave; the debug host or
// testbench is the master.
interface dbg_run_control_if #(
    parameter int STEP_W = 8,
    parameter int CNT_W  = 32
);
    logic              halt_stb;
    logic              step_stb;
    logic              resume_stb;
    logic              rst_stb;
    logic [STEP_W-1:0] step_count;
    logic              core_idle;
    logic              dbg_clk;
    logic              clk_en;
    logic              halted;
    logic              stepping;
    logic              core_rst_n;
    logic              halt_timeout;
    logic [CNT_W-1:0]  cycle_cnt;

    modport master (
        output halt_stb, step_stb, resume_stb, rst_stb, step_count, core_idle,
        input  dbg_clk, clk_en, halted, stepping, core_rst_n, halt_timeout, cycle_cnt
    );

    modport slave (
        input  halt_stb, step_stb, resume_stb, rst_stb, step_count, core_idle,
        output dbg_clk, clk_en, halted, stepping, core_rst_n, halt_timeout, cycle_cnt
    );
endinterface

// File: rtl/dbg_run_control.sv
// Debug run-control engine: halt at core-idle boundary (with timeout),
// N-cycle stepping, timed core reset, glitch-free gated core clock and
// enabled-cycle counter.
module dbg_run_control #(
    parameter int STEP_W     = 8,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 64,
    parameter int RST_CYCLES = 4
) (
    input  logic               sys_clk,
    input  logic               dbg_rst,
    dbg_run_control_if.slave   bus
);
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam int RST_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_HALT_PEND,
        ST_HALTED,
        ST_STEP,
        ST_CORE_RST
    } state_t;

    state_t            r_state;
    logic              r_clk_en;
    logic              r_clk_gate;
    logic              r_halted;
    logic              r_stepping;
    logic              r_core_rst_n;
    logic              r_halt_timeout;
    logic              r_ret_halted;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic [STEP_W-1:0] r_step_left;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [RST_W-1:0]  r_rst_left;
    logic [STEP_W-1:0] w_step_load;

    assign w_step_load = (bus.step_count == '0) ? STEP_W'(1) : bus.step_count;

    // Run-control FSM with registered status outputs and cycle counter
    always_ff @(posedge sys_clk or negedge dbg_rst) begin
        if (!dbg_rst) begin
            r_state        <= ST_RUN;
            r_clk_en       <= 1'b1;
            r_halted       <= 1'b0;
            r_stepping     <= 1'b0;
            r_core_rst_n   <= 1'b1;
            r_halt_timeout <= 1'b0;
            r_ret_halted   <= 1'b0;
            r_cycle_cnt    <= '0;
            r_step_left    <= '0;
            r_tmo_cnt      <= '0;
            r_rst_left     <= '0;
        end else begin
            // Counts the dbg_clk edge occurring at this posedge; a reset
            // strobe below overrides it with a clear.
            if (r_clk_gate) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if (bus.rst_stb) begin
                r_ret_halted   <= (r_state != ST_RUN);
                r_rst_left     <= RST_W'(RST_CYCLES);
                r_core_rst_n   <= 1'b0;
                r_clk_en       <= 1'b1;
                r_cycle_cnt    <= '0;
                r_halt_timeout <= 1'b0;
                r_state        <= ST_CORE_RST;
                r_halted       <= 1'b0;
                r_stepping     <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_RUN: begin
                        if (bus.halt_stb) begin
                            if (bus.core_idle) begin
                                r_state  <= ST_HALTED;
                                r_halted <= 1'b1;
                                r_clk_en <= 1'b0;
                            end else begin
                                r_state   <= ST_HALT_PEND;
                                r_tmo_cnt <= '0;
                            end
                        end
                    end
                    ST_HALT_PEND: begin
                        if (bus.resume_stb) begin
                            r_state <= ST_RUN;
                        end else if (bus.core_idle) begin
                            r_state  <= ST_HALTED;
                            r_halted <= 1'b1;
                            r_clk_en <= 1'b0;
                        end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                            r_state        <= ST_HALTED;
                            r_halted       <= 1'b1;
                            r_clk_en       <= 1'b0;
                            r_halt_timeout <= 1'b1;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                        end
                    end
                    ST_HALTED: begin
                        if (bus.step_stb) begin
                            r_state     <= ST_STEP;
                            r_halted    <= 1'b0;
                            r_stepping  <= 1'b1;
                            r_step_left <= w_step_load;
                            r_clk_en    <= 1'b1;
                        end else if (bus.resume_stb) begin
                            r_state        <= ST_RUN;
                            r_halted       <= 1'b0;
                            r_clk_en       <= 1'b1;
                            r_halt_timeout <= 1'b0;
                        end
                    end
                    ST_STEP: begin
                        if (bus.resume_stb) begin
                            r_state    <= ST_RUN;
                            r_stepping <= 1'b0;
                        end else if (r_step_left == STEP_W'(1)) begin
                            r_state    <= ST_HALTED;
                            r_stepping <= 1'b0;
                            r_halted   <= 1'b1;
                            r_clk_en   <= 1'b0;
                        end else begin
                            r_step_left <= r_step_left - STEP_W'(1);
                        end
                    end
                    ST_CORE_RST: begin
                        if (r_rst_left == RST_W'(1)) begin
                            r_core_rst_n <= 1'b1;
                            r_state      <= r_ret_halted ? ST_HALTED : ST_RUN;
                            r_halted     <= r_ret_halted;
                            r_clk_en     <= !r_ret_halted;
                        end else begin
                            r_rst_left <= r_rst_left - RST_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_RUN;
                    end
                endcase
            end
        end
    end

    // Gate flop on the falling edge so enable changes land while sys_clk is low
    always_ff @(negedge sys_clk or negedge dbg_rst) begin
        if (!dbg_rst) begin
            r_clk_gate <= 1'b1;
        end else begin
            r_clk_gate <= r_clk_en;
        end
    end

    assign bus.dbg_clk      = sys_clk & r_clk_gate;
    assign bus.clk_en       = r_clk_en;
    assign bus.halted       = r_halted;
    assign bus.stepping     = r_stepping;
    assign bus.core_rst_n   = r_core_rst_n;
    assign bus.halt_timeout = r_halt_timeout;
    assign bus.cycle_cnt    = r_cycle_cnt;
endmodule

// File: tb/tb_dbg_run_control.sv
// Scoreboard bench for dbg_run_control: a reference model driven by absolute
// edge deadlines predicts each posedge's outputs; a monitor compares them.
module tb_dbg_run_control;
    localparam int STEP_W     = 8;
    localparam int CNT_W      = 4;
    localparam int TIMEOUT    = 64;
    localparam int RST_CYCLES = 4;

    logic sys_clk = 1'b0;
    logic dbg_rst = 1'b1;
    bit   idle_lvl = 1'b1;

    dbg_run_control_if #(.STEP_W(STEP_W), .CNT_W(CNT_W)) u_if ();

    dbg_run_control #(
        .STEP_W    (STEP_W),
        .CNT_W     (CNT_W),
        .TIMEOUT   (TIMEOUT),
        .RST_CYCLES(RST_CYCLES)
    ) u_dut (
        .sys_clk(sys_clk),
        .dbg_rst(dbg_rst),
        .bus    (u_if)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit          halted;
        bit          stepping;
        bit          rstn;
        bit          tmo;
        bit          en;
        bit          pulse;
        int unsigned cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: behaviour expressed as absolute edge numbers at which
    // the halt deadline, step end and reset end fall.
    typedef enum {M_RUN, M_WAIT, M_STOP, M_STEP, M_RST} mode_t;
    mode_t       m_mode;
    bit          m_en, m_rstn, m_tmo, m_ret;
    int unsigned m_cnt;
    longint      m_cyc, m_deadline, m_step_end, m_rst_end;

    initial begin
        exp_t e;
        bit   prev_en;
        m_cyc = 0;
        forever begin
            @(posedge sys_clk);
            m_cyc++;
            if (!dbg_rst) begin
                m_mode = M_RUN; m_en = 1; m_rstn = 1; m_tmo = 0; m_cnt = 0;
                prev_en = 1;
            end else begin
                prev_en = m_en;
                if (prev_en) m_cnt = (m_cnt + 1) % (1 << CNT_W);
                if (u_if.rst_stb) begin
                    m_ret = (m_mode != M_RUN);
                    m_rst_end = m_cyc + RST_CYCLES;
                    m_mode = M_RST; m_en = 1; m_cnt = 0; m_tmo = 0; m_rstn = 0;
                end else begin
                    case (m_mode)
                        M_RUN:
                            if (u_if.halt_stb) begin
                                if (u_if.core_idle) begin m_mode = M_STOP; m_en = 0; end
                                else begin m_mode = M_WAIT; m_deadline = m_cyc + TIMEOUT; end
                            end
                        M_WAIT:
                            if (u_if.resume_stb) m_mode = M_RUN;
                            else if (u_if.core_idle) begin m_mode = M_STOP; m_en = 0; end
                            else if (m_cyc == m_deadline) begin
                                m_mode = M_STOP; m_en = 0; m_tmo = 1;
                            end
                        M_STOP:
                            if (u_if.step_stb) begin
                                m_mode = M_STEP; m_en = 1;
                                m_step_end = m_cyc + ((u_if.step_count == 0) ? 1 : u_if.step_count);
                            end else if (u_if.resume_stb) begin
                                m_mode = M_RUN; m_en = 1; m_tmo = 0;
                            end
                        M_STEP:
                            if (u_if.resume_stb) m_mode = M_RUN;
                            else if (m_cyc == m_step_end) begin m_mode = M_STOP; m_en = 0; end
                        M_RST:
                            if (m_cyc == m_rst_end) begin
                                m_rstn = 1;
                                m_mode = m_ret ? M_STOP : M_RUN;
                                m_en = !m_ret;
                            end
                        default: m_mode = M_RUN;
                    endcase
                end
            end
            e.halted   = (m_mode == M_STOP);
            e.stepping = (m_mode == M_STEP);
            e.rstn     = m_rstn;
            e.tmo      = m_tmo;
            e.en       = m_en;
            e.pulse    = prev_en;
            e.cnt      = m_cnt;
            sb.push_back(e);
        end
    end

    // Monitor: after every posedge, compare the DUT against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("dbg_clk_pulse", u_if.dbg_clk, e.pulse);
                chk("clk_en", u_if.clk_en, e.en);
                chk("halted", u_if.halted, e.halted);
                chk("stepping", u_if.stepping, e.stepping);
                chk("core_rst_n", u_if.core_rst_n, e.rstn);
                chk("halt_timeout", u_if.halt_timeout, e.tmo);
                chk("cycle_cnt", u_if.cycle_cnt, e.cnt);
            end
        end
    end

    task automatic tick(input bit h, input bit s, input bit rs, input bit r, input int n);
        @(negedge sys_clk);
        u_if.halt_stb   = h;
        u_if.step_stb   = s;
        u_if.resume_stb = rs;
        u_if.rst_stb    = r;
        u_if.step_count = STEP_W'(n);
        u_if.core_idle  = idle_lvl;
    endtask

    task automatic idle_n(input int n);
        repeat (n) tick(0, 0, 0, 0, 0);
    endtask

    initial begin
        u_if.halt_stb = 0; u_if.step_stb = 0; u_if.resume_stb = 0; u_if.rst_stb = 0;
        u_if.step_count = '0; u_if.core_idle = 1'b1;
        #1 dbg_rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        dbg_rst = 1'b1;

        // Halt at edge 10 with core idle, then steps of 5 and 0
        idle_n(8);
        tick(1, 0, 0, 0, 0);
        idle_n(5);
        tick(0, 1, 0, 0, 5);
        idle_n(8);
        tick(0, 1, 0, 0, 0);
        idle_n(4);
        // Step and resume together while halted: step wins
        tick(0, 1, 1, 0, 2);
        idle_n(5);
        tick(0, 0, 1, 0, 0);
        idle_n(5);

        // Forced halt by timeout, then resume clears the sticky flag
        idle_lvl = 1'b0;
        tick(1, 0, 0, 0, 0);
        idle_n(70);
        tick(0, 0, 1, 0, 0);
        idle_n(5);
        idle_lvl = 1'b1;

        // Core reset from HALTED, then reset+step from RUN
        tick(1, 0, 0, 0, 0);
        idle_n(2);
        tick(0, 0, 0, 1, 0);
        idle_n(8);
        tick(0, 0, 1, 0, 0);
        idle_n(3);
        tick(0, 1, 0, 1, 3);
        idle_n(8);

        // Resume after three pulses of a 20-cycle step
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 20);
        idle_n(2);
        tick(0, 0, 1, 0, 0);
        idle_n(10);

        // Asynchronous reset in the middle of a long step
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 200);
        idle_n(20);
        @(posedge sys_clk);
        #2 dbg_rst = 1'b0;
        #1;
        chk("async_dbg_clk", u_if.dbg_clk, 1);
        chk("async_clk_en", u_if.clk_en, 1);
        chk("async_halted", u_if.halted, 0);
        chk("async_stepping", u_if.stepping, 0);
        chk("async_core_rst_n", u_if.core_rst_n, 1);
        chk("async_halt_timeout", u_if.halt_timeout, 0);
        chk("async_cycle_cnt", u_if.cycle_cnt, 0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        dbg_rst = 1'b1;
        idle_n(40);

        // Randomized strobe traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) idle_lvl = !idle_lvl;
            tick($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 59) == 0,
                 int'($urandom_range(0, 6)));
        end
        idle_n(3);
        @(posedge sys_clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
